// File: rtl/decompose_pkg.sv
// Shared FSM encoding and signed-digit constants for the decompose scheduler.
`ifndef DATA_SIZE_ARB
`define DATA_SIZE_ARB 32
`endif
`ifndef MODULUS
`define MODULUS 132120577
`endif
`ifndef MODULUSHALF
`define MODULUSHALF 66060288
`endif

package decompose_pkg;
  localparam int unsigned DATA_SIZE_ARB = `DATA_SIZE_ARB;
  localparam int unsigned MODULUS       = `MODULUS;
  localparam int unsigned MODULUS_HALF  = `MODULUSHALF;

  localparam int unsigned DIGIT_BASE = 128;
  localparam int unsigned DIGIT_HALF = 64;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;
endpackage

// File: rtl/signedDigitDecompose.sv
// Combinational base-128 balanced-digit split of a centred residue; digits reduced mod MODULUS.
module signedDigitDecompose
  import decompose_pkg::*;
#(
  parameter int unsigned W = DATA_SIZE_ARB
) (
  input  logic [W-1:0] value,
  output logic [W-1:0] digit0,
  output logic [W-1:0] digit1,
  output logic [W-1:0] digit2,
  output logic [W-1:0] digit3
);
  logic [W-1:0] rem;
  logic [6:0]   slice;
  logic [W-1:0] dig [4];

  always_comb begin
    rem   = (value < W'(MODULUS_HALF)) ? value : value - W'(MODULUS);
    slice = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      slice = rem[6:0];
      // A high slice becomes negative and pushes a carry into the arithmetic remainder.
      if (slice >= 7'(DIGIT_HALF)) begin
        dig[i] = W'(slice) + W'(MODULUS) - W'(DIGIT_BASE);
        rem    = W'($signed(rem) >>> 7) + W'(1);
      end else begin
        dig[i] = W'(slice);
        rem    = W'($signed(rem) >>> 7);
      end
    end
    dig[3] = rem[5] ? W'(MODULUS) - W'(DIGIT_HALF) + W'(rem[5:0]) : W'(rem[5:0]);
  end

  assign digit0 = dig[0];
  assign digit1 = dig[1];
  assign digit2 = dig[2];
  assign digit3 = dig[3];
endmodule

// File: rtl/skid_fifo2.sv
// Two-entry FIFO skid buffer with registered storage and occupancy report.
module skid_fifo2 #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pushValid,
  input  logic [DW-1:0] pushData,
  input  logic          popReady,
  output logic          popValid,
  output logic [DW-1:0] popData,
  output logic [1:0]    occupancy
);
  logic [DW-1:0] mem [2];
  logic          wrPtr;
  logic          rdPtr;
  logic [1:0]    count;
  logic          doPush;
  logic          doPop;

  assign doPop  = popReady && (count != 2'd0);
  assign doPush = pushValid && ((count != 2'd2) || doPop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wrPtr  <= 1'b0;
      rdPtr  <= 1'b0;
      count  <= '0;
    end else begin
      if (doPush) begin
        mem[wrPtr] <= pushData;
        wrPtr      <= !wrPtr;
      end
      if (doPop) rdPtr <= !rdPtr;
      case ({doPush, doPop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign popValid  = (count != 2'd0);
  assign popData   = mem[rdPtr];
  assign occupancy = count;
endmodule

// File: rtl/decompose_scheduler.sv
// Streams one polynomial from coefficient RAM through signed-digit decomposition
// into a credit-controlled two-entry output buffer.
module decompose_scheduler
  import decompose_pkg::*;
#(
  parameter int unsigned N_COEFF = 1024,
  parameter int unsigned AW      = $clog2(N_COEFF),
  parameter int unsigned W       = DATA_SIZE_ARB
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [W-1:0]  rd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_index,
  output logic [W-1:0]  out_digit0,
  output logic [W-1:0]  out_digit1,
  output logic [W-1:0]  out_digit2,
  output logic [W-1:0]  out_digit3
);
  localparam int unsigned DW = AW + 4 * W;
  localparam logic [AW-1:0] LAST_ADDR = AW'(N_COEFF - 1);

  logic [1:0]    state;
  logic [AW-1:0] addrQ;
  logic [AW-1:0] flightIdx;
  logic          inFlight;
  logic [1:0]    occupancy;
  logic          pop;
  logic          drainDone;
  logic [W-1:0]  dig0, dig1, dig2, dig3;
  logic [DW-1:0] pushData;
  logic [DW-1:0] popData;

  assign pop   = out_valid && out_ready;
  assign rd_en = (state == ST_RUN) &&
                 (({1'b0, occupancy} + {2'b0, inFlight} - {2'b0, pop}) < 3'd2);
  // Judged on next-cycle emptiness so done lands one cycle after the final pop.
  assign drainDone = !inFlight && ((occupancy == 2'd0) || ((occupancy == 2'd1) && pop));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      addrQ     <= '0;
      inFlight  <= 1'b0;
      flightIdx <= '0;
    end else begin
      inFlight <= rd_en;
      if (rd_en) flightIdx <= addrQ;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_RUN;
            addrQ <= '0;
          end
        end
        ST_RUN: begin
          if (rd_en) begin
            if (addrQ == LAST_ADDR) state <= ST_DRAIN;
            else                    addrQ <= addrQ + AW'(1);
          end
        end
        ST_DRAIN: if (drainDone) state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE);
  assign rd_addr = addrQ;

  // rd_data is captured by the buffer entry itself, keeping read-to-beat latency at 2.
  signedDigitDecompose #(.W(W)) uDecompose (
    .value  (rd_data),
    .digit0 (dig0),
    .digit1 (dig1),
    .digit2 (dig2),
    .digit3 (dig3)
  );

  assign pushData = {flightIdx, dig3, dig2, dig1, dig0};

  skid_fifo2 #(.DW(DW)) uSkid (
    .clk       (clk),
    .rst_n     (rst_n),
    .pushValid (inFlight),
    .pushData  (pushData),
    .popReady  (out_ready),
    .popValid  (out_valid),
    .popData   (popData),
    .occupancy (occupancy)
  );

  assign {out_index, out_digit3, out_digit2, out_digit1, out_digit0} = popData;
endmodule

// File: tb/tb_decompose_scheduler.sv
// Scoreboard bench for decompose_scheduler: RAM model, reference digit split, stalls, abort and restart.
module tb_decompose_scheduler;
  import decompose_pkg::*;

  localparam int unsigned N  = 1024;
  localparam int unsigned AW = 10;
  localparam int unsigned W  = DATA_SIZE_ARB;
  localparam int unsigned EW = AW + 4 * W;
  typedef logic [EW-1:0] entry_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          busy, done, rd_en;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data = '0;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_index;
  logic [W-1:0]  out_digit0, out_digit1, out_digit2, out_digit3;

  decompose_scheduler #(.N_COEFF(N), .AW(AW), .W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_index  (out_index),
    .out_digit0 (out_digit0),
    .out_digit1 (out_digit1),
    .out_digit2 (out_digit2),
    .out_digit3 (out_digit3)
  );

  always #5 clk = ~clk;

  logic [W-1:0]   ram [N];
  logic [4*W-1:0] litTab [4];

  always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

  int     checks = 0;
  int     errors = 0;
  entry_t q[$];
  int     cyc = 0;
  int     nextAddr, passBeats, passDones, busyCnt;
  int     firstRd, firstOv, lastBeatCyc, doneCyc;
  bit     prevDone = 1'b0;

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4*W-1:0] refDigits(input logic [W-1:0] v);
    longint mod, x, r, dg;
    logic [4*W-1:0] res;
    mod = longint'(MODULUS);
    res = '0;
    x = (longint'(v) < longint'(MODULUS_HALF)) ? longint'(v) : longint'(v) - mod;
    for (int k = 0; k < 3; k++) begin
      r = x % 128;
      if (r < 0) r += 128;
      dg = (r >= 64) ? r - 128 : r;
      x = (x - dg) / 128;
      res[k*W +: W] = W'((dg < 0) ? dg + mod : dg);
    end
    r = x % 64;
    if (r < 0) r += 64;
    dg = (r >= 32) ? r - 64 : r;
    res[3*W +: W] = W'((dg < 0) ? dg + mod : dg);
    return res;
  endfunction

  task automatic monitorCycle();
    bit     popNow;
    entry_t e;
    popNow = out_valid && out_ready;
    if (rst_n) begin
      if (prevDone) check("idle after done", busy, 0);
      if (busy) busyCnt++;
      if (done) begin
        passDones++;
        doneCyc = cyc;
        check("done after last beat", cyc - lastBeatCyc, 1);
      end
      if (out_valid) begin
        if (firstOv < 0) firstOv = cyc;
        if (q.size() == 0) check("unexpected beat", out_valid, 0);
        else begin
          e = q[0];
          check("out_index", out_index, e[4*W +: AW]);
          check("out_digits", {out_digit3, out_digit2, out_digit1, out_digit0}, e[4*W-1:0]);
        end
      end
      if (popNow && passBeats < 4)
        check("literal digits", {out_digit3, out_digit2, out_digit1, out_digit0}, litTab[passBeats]);
      if (rd_en) begin
        if (firstRd < 0) firstRd = cyc;
        check("credit", ((q.size() - int'(popNow)) < 2), 1);
        check("rd_addr", rd_addr, nextAddr);
        q.push_back({rd_addr, refDigits(ram[rd_addr])});
        nextAddr++;
      end
      if (popNow && q.size() != 0) begin
        void'(q.pop_front());
        passBeats++;
        lastBeatCyc = cyc;
      end
    end
    prevDone = rst_n && done;
    cyc++;
  endtask

  task automatic clkStep();
    #1;
    monitorCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " rd_en"}, rd_en, 0);
    check({tag, " out_valid"}, out_valid, 0);
    check({tag, " rd_addr"}, rd_addr, 0);
    check({tag, " out_index"}, out_index, 0);
    check({tag, " digits"}, {out_digit3, out_digit2, out_digit1, out_digit0}, 0);
  endtask

  task automatic runPass(input bit stall, input bit startNoise, input int abortAt, output bit aborted);
    int guard;
    int c0;
    passBeats = 0; passDones = 0; nextAddr = 0; busyCnt = 0;
    firstRd = -1; firstOv = -1; lastBeatCyc = -1; doneCyc = -1;
    aborted = 1'b0;
    start = 1'b1;
    out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    c0 = cyc;
    clkStep();
    start = 1'b0;
    check("busy after start", busy, 1);
    guard = 0;
    while (passDones == 0 && guard < 20000) begin
      if (abortAt >= 0 && passBeats >= abortAt) begin
        aborted = 1'b1;
        break;
      end
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      // Holding start once all beats are out lands it on the done cycle.
      start = (passBeats >= N) ? 1'b1 : (startNoise && ($urandom_range(0, 7) == 0));
      clkStep();
      guard++;
    end
    start = 1'b0;
    if (!aborted) begin
      check("done count", passDones, 1);
      check("beat count", passBeats, N);
      check("queue empty", q.size(), 0);
      check("busy span", busyCnt, doneCyc - c0);
      check("first beat latency", firstOv - firstRd, 2);
      check("rd_addr saturated", rd_addr, N - 1);
      if (!stall) check("busy >= 1026", (busyCnt >= 1026), 1);
    end
  endtask

  initial begin
    bit aborted;
    rst_n = 1'b0;
    start = 1'b0;
    out_ready = 1'b1;
    ram[0] = '0;
    ram[1] = W'(63);
    ram[2] = W'(64);
    ram[3] = W'(MODULUS - 1);
    for (int i = 4; i < int'(N); i++) ram[i] = W'($urandom % MODULUS);
    litTab[0] = '0;
    litTab[1] = {W'(0), W'(0), W'(0), W'(63)};
    litTab[2] = {W'(0), W'(0), W'(1), W'(MODULUS - 64)};
    litTab[3] = {W'(0), W'(0), W'(0), W'(MODULUS - 1)};

    @(posedge clk);
    #1;
    clkStep();
    clkStep();
    checkResetOutputs("reset");
    rst_n = 1'b1;
    clkStep();

    runPass(1'b0, 1'b0, -1, aborted);
    runPass(1'b1, 1'b1, -1, aborted);

    runPass(1'b1, 1'b0, 300, aborted);
    check("abort reached", aborted, 1);
    rst_n = 1'b0;
    clkStep();
    clkStep();
    checkResetOutputs("abort reset");
    rst_n = 1'b1;
    q.delete();
    passDones = 0;
    for (int i = 0; i < 6; i++) clkStep();
    check("no done after abort", passDones, 0);
    check("idle out_valid after abort", out_valid, 0);

    runPass(1'b1, 1'b0, -1, aborted);
    for (int i = 0; i < 3; i++) clkStep();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/decompose_scheduler.md
DECOMPOSE_SCHEDULER -- requirements
Module: decompose_scheduler

Interface
REQ-001 Parameter N_COEFF, default 1024: coefficients per polynomial; power of two, 4..4096.
REQ-002 Parameter AW, default $clog2(N_COEFF): coefficient address width.
REQ-003 Parameter W, default `DATA_SIZE_ARB: coefficient and digit width.
REQ-004 One clock; reset is synchronous and active-low.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 start  input  1  one-cycle pulse; begins one polynomial pass when idle.
REQ-008 busy  output  1  high from the cycle after an accepted start until the cycle done pulses.
REQ-009 done  output  1  one-cycle pulse after the last output beat is accepted.
REQ-010 rd_en  output  1  coefficient RAM read strobe.
REQ-011 rd_addr  output  AW  coefficient RAM address, valid with rd_en.
REQ-012 rd_data  input  W  RAM data, valid exactly 1 cycle after rd_en.
REQ-013 out_valid  output  1  output beat valid.
REQ-014 out_ready  input  1  downstream accepts the beat when high with out_valid.
REQ-015 out_index  output  AW  coefficient index of the current beat.
REQ-016 out_digit0..out_digit3  output  W each  base-128 signed digits, least significant first, each reduced mod `MODULUS.

Function
REQ-017 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-018 IDLE->RUN on start; in all other states start is ignored.
REQ-019 RUN issues reads at addresses 0..N_COEFF-1 in ascending order; RUN->DRAIN in the cycle the read at address N_COEFF-1 is issued.
REQ-020 DRAIN->DONE when no read is in flight and the skid buffer is empty; DONE->IDLE after one cycle; done is high only in DONE.
REQ-021 Digit rule: d = value if value < `MODULUSHALF, else value - `MODULUS (two's complement, W bits).
REQ-022 Digit rule: each 7-bit slice r is taken with an incoming carry; if r >= 64, emit r + `MODULUS - 128 and carry 1 into the next slice; otherwise emit r.
REQ-023 Digit rule: the fourth slice is sign-extended from bit 5 of the remaining bits.
REQ-024 rd_data is registered, then decomposed; digits are written into a 2-entry FIFO skid buffer that drives out_*.
REQ-025 Credit rule: a read is issued in a cycle only if (buffer occupancy + reads in flight - beat popped this cycle) < 2.
REQ-026 With out_ready held high, the pass sustains 1 beat/cycle.
REQ-027 Latency from the first rd_en to the first out_valid is 2 cycles.
REQ-028 While out_valid && !out_ready, out_index and out_digit* stay stable and no beat is lost or duplicated.
REQ-029 A push and a pop in the same cycle leave occupancy unchanged; the buffer never exceeds 2 entries.
REQ-030 Beats emerge in ascending out_index order, exactly N_COEFF beats per pass.
REQ-031 The address counter saturates; it does not wrap.
REQ-032 start in the same cycle as done is ignored; start in the cycle after done is accepted.

Reset
REQ-033 On rst_n low at a clock edge: FSM=IDLE, counters=0, buffer empty; busy, done, rd_en, out_valid=0; rd_addr, out_index, out_digit*=0.
REQ-034 Reset mid-pass aborts the pass with no done pulse; rd_data arriving after reset is discarded.

Structure
REQ-035 FSM state encoding and the digit constants (base 128, half-base 64) go in shared package decompose_pkg, alongside `MODULUS/`MODULUSHALF from defines.v.
REQ-036 Digit computation is the existing combinational signedDigitDecompose, instantiated once; the FIFO skid buffer is a sub-module named skid_fifo2.

Verification
REQ-037 RAM holds 0, 63, 64, `MODULUS-1; out_ready=1 -> digits (0,0,0,0); (63,0,0,0); (`MODULUS-64,1,0,0); (`MODULUS-1,0,0,0).
REQ-038 N_COEFF=1024, out_ready=1 -> 1024 consecutive beats; done exactly 1 cycle after the last beat; busy high for 1026+ cycles.
REQ-039 out_ready toggles pseudo-randomly at 50% -> outputs are stable while stalled, no rd_en issued once 2 beats are pending, index sequence is 0..1023 gapless.
REQ-040 rst_n low at beat 300, then start -> no done from the aborted pass; the new pass restarts at index 0 with correct digits.
REQ-041 start while busy, and start coincident with done -> ignored; exactly one pass and one done each.
